// File: rtl/bnn_param_loader_pkg.sv
// ----------------------------------------------------------------------------
// bnn_param_loader_pkg
//   Shared definitions for the neuron parameter loader: default chain
//   geometry, the loader FSM state encoding and the chain-length formula.
//   The neuron cells use the same geometry, so the formula lives here once.
// ----------------------------------------------------------------------------
package bnn_param_loader_pkg;

    localparam int DEF_INPUTS    = 8;   // synapse (weight) bits per neuron
    localparam int DEF_BIAS_BITS = 3;   // bias bits per neuron
    localparam int DEF_NEURONS   = 4;   // neurons in the daisy chain
    localparam int BYTE_W        = 8;   // width of the host byte interface

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Total number of parameter bits held by the whole chain.
    function automatic int chain_bits(input int inputs, input int bias_bits,
                                      input int neurons);
        return neurons * (inputs + bias_bits);
    endfunction

endpackage

// File: rtl/bnn_param_loader.sv
// ----------------------------------------------------------------------------
// bnn_param_loader
//   Upstream feeder for the neuron parameter daisy chain. Accepts parameter
//   bytes over a valid/ready handshake and serialises them MSB-first onto the
//   chain's setup/param_out pair. Exactly NEURONS*(INPUTS+BIAS_BITS) bits are
//   shifted per load, after which done is raised and held until the next
//   start or reset. The host orders the byte stream last-neuron-first,
//   bias-before-weights, because the first bit shifted travels furthest.
//
// Ports
//   clk        in   clock, all state on posedge
//   rst_n      in   asynchronous reset, active low
//   start      in   one-cycle pulse: begin a new load (ignored while loading)
//   in_data    in   parameter byte, MSB shifted first
//   in_valid   in   in_data valid
//   in_ready   out  loader accepts in_data this cycle
//   setup      out  chain shift enable, one bit per cycle while high
//   param_out  out  current bit to the first neuron's param_in
//   busy       out  load in progress
//   done       out  full chain loaded
// ----------------------------------------------------------------------------
module bnn_param_loader
    import bnn_param_loader_pkg::*;
#(
    parameter int INPUTS    = DEF_INPUTS,
    parameter int BIAS_BITS = DEF_BIAS_BITS,
    parameter int NEURONS   = DEF_NEURONS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              setup,
    output logic              param_out,
    output logic              busy,
    output logic              done
);

    localparam int TOTAL_BITS = chain_bits(INPUTS, BIAS_BITS, NEURONS);
    localparam int CNT_BITS   = $clog2(TOTAL_BITS + 1);
    localparam int BC_W       = $clog2(BYTE_W + 1);

    state_e              state_q, state_d;
    logic [BYTE_W-1:0]   sr_q, sr_d;
    logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [CNT_BITS-1:0] remaining_q, remaining_d;

    logic shifting;
    logic accept;

    // All outputs are decodes of registered state only, so nothing from the
    // input pins reaches the chain combinationally.
    assign shifting  = (state_q == ST_LOAD) && (bit_cnt_q != '0);
    assign in_ready  = (state_q == ST_LOAD) && (bit_cnt_q == '0) && (remaining_q != '0);
    assign accept    = in_valid && in_ready;

    assign setup     = shifting;
    assign param_out = shifting & sr_q[BYTE_W-1];
    assign busy      = (state_q == ST_LOAD);
    assign done      = (state_q == ST_DONE);

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        remaining_d = remaining_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_LOAD;
                    remaining_d = CNT_BITS'(TOTAL_BITS);
                    bit_cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                // Acceptance only happens with an empty shift register, so it
                // never overlaps with shifting; the empty cycle between bytes
                // is the bubble that gives 9 cycles per byte.
                if (accept) begin
                    sr_d      = in_data;
                    bit_cnt_d = BC_W'(BYTE_W);
                end else if (shifting && (remaining_q != '0)) begin
                    sr_d        = {sr_q[BYTE_W-2:0], 1'b0};
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == CNT_BITS'(1)) begin
                        // Last chain bit: drop the unused low bits of a
                        // partial final byte and finish on this edge.
                        bit_cnt_d = '0;
                        state_d   = ST_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            remaining_q <= remaining_d;
        end
    end

endmodule

// File: tb/tb_bnn_param_loader.sv
// ----------------------------------------------------------------------------
// tb_bnn_param_loader
//   Directed bench for bnn_param_loader. A queue-based model of the loader
//   is stepped once per cycle and compared against the DUT outputs; a
//   44-bit shift register stands in for the 4-neuron chain. Literal chain
//   contents pin both the DUT and the model.
// ----------------------------------------------------------------------------
module tb_bnn_param_loader;

    localparam int TOTAL = 44;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       setup;
    logic       param_out;
    logic       busy;
    logic       done;

    bnn_param_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .setup     (setup),
        .param_out (param_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model state: phase, bits of the current byte still to shift, bits left
    // in the load, and the chain image the model expects.
    typedef enum int {M_IDLE, M_LOAD, M_DONE} mphase_e;
    mphase_e     m_phase = M_IDLE;
    bit          m_q[$];
    int          m_left  = 0;
    logic [43:0] m_chain = '0;

    // Chain image built from what the DUT actually drives.
    logic [43:0] dut_chain   = '0;
    int          setup_total = 0;

    logic [7:0]  tbl[6];
    int          acc_cyc[6];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: step the model with the inputs the DUT sampled at the
    // preceding posedge, then compare the DUT outputs of the current cycle.
    task automatic tick();
        bit   b;
        logic e_setup, e_pout, e_ready, e_busy, e_done;
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            m_phase = M_IDLE;
            m_q.delete();
            m_left  = 0;
        end else if (start && m_phase != M_LOAD) begin
            m_phase = M_LOAD;
            m_left  = TOTAL;
            m_q.delete();
        end else if (m_phase == M_LOAD) begin
            if (m_q.size() == 0 && m_left > 0) begin
                if (in_valid)
                    for (int i = 7; i >= 0; i--) m_q.push_back(in_data[i]);
            end else if (m_q.size() > 0) begin
                b       = m_q.pop_front();
                m_chain = {m_chain[42:0], b};
                m_left--;
                if (m_left == 0) begin
                    m_q.delete();
                    m_phase = M_DONE;
                end
            end
        end
        e_setup = (m_phase == M_LOAD) && (m_q.size() > 0);
        e_pout  = 1'b0;
        if (e_setup) e_pout = m_q[0];
        e_ready = (m_phase == M_LOAD) && (m_q.size() == 0) && (m_left > 0);
        e_busy  = (m_phase == M_LOAD);
        e_done  = (m_phase == M_DONE);
        check("setup",     setup,     e_setup);
        check("param_out", param_out, e_pout);
        check("in_ready",  in_ready,  e_ready);
        check("busy",      busy,      e_busy);
        check("done",      done,      e_done);
        if (setup) begin
            setup_total++;
            dut_chain = {dut_chain[42:0], param_out};
        end
    endtask

    task automatic wait_ready(input string name);
        int k = 0;
        while (!in_ready && k < 40) begin
            tick();
            k++;
        end
        check(name, in_ready, 1'b1);
    endtask

    // Full load of tbl[]: optional 5-cycle valid gap before byte gap_after+1,
    // optional start pulse right after byte start_after is accepted.
    task automatic run_load(input int gap_after, input int start_after);
        int k = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_done_clr", done, 1'b0);
        check("start_busy", busy, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (i == gap_after + 1) begin
                wait_ready("gap_ready_timeout");
                repeat (5) tick();
            end
            in_data  = tbl[i];
            in_valid = 1'b1;
            wait_ready("ready_timeout");
            acc_cyc[i] = cyc;
            tick();
            in_valid = 1'b0;
            check("first_setup", setup, 1'b1);
            check("first_bit", param_out, tbl[i][7]);
            if (i == start_after) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        while (!done && k < 100) begin
            tick();
            k++;
        end
        check("done_timeout", done, 1'b1);
    endtask

    task automatic check_intervals(input int gap_after);
        for (int i = 1; i < 6; i++)
            if (i != gap_after + 1)
                check("accept_interval", acc_cyc[i] - acc_cyc[i-1], 9);
    endtask

    int base;

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Async reset visible before any clock edge.
        #2;
        check("rst_setup",    setup,     1'b0);
        check("rst_param",    param_out, 1'b0);
        check("rst_in_ready", in_ready,  1'b0);
        check("rst_busy",     busy,      1'b0);
        check("rst_done",     done,      1'b0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Full back-to-back load.
        tbl = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'hF0};
        base = setup_total;
        run_load(99, 99);
        check("full_setup_cnt", setup_total - base, TOTAL);
        check("full_chain",     dut_chain, 44'hA53CFF0081F);
        check("model_chain",    m_chain,   44'hA53CFF0081F);
        check("n3_bias",        dut_chain[43:41], 3'b101);
        check("n0_weights",     dut_chain[7:0],   8'h1F);
        check_intervals(99);
        check("full_span",      acc_cyc[5] - acc_cyc[0], 45);
        repeat (3) tick();
        check("done_held",      done, 1'b1);

        // Backpressure: 5 idle cycles with ready high before byte 3.
        dut_chain = '0;
        base = setup_total;
        run_load(1, 99);
        check("bp_setup_cnt", setup_total - base, TOTAL);
        check("bp_chain",     dut_chain, 44'hA53CFF0081F);
        check_intervals(1);
        check("bp_span",      acc_cyc[5] - acc_cyc[0], 50);
        tick();

        // Start pulse during LOAD after byte 3 is ignored.
        dut_chain = '0;
        base = setup_total;
        run_load(99, 2);
        check("sdl_setup_cnt", setup_total - base, TOTAL);
        check("sdl_chain",     dut_chain, 44'hA53CFF0081F);
        check_intervals(99);
        tick();

        // Reload from DONE with all-zero bytes.
        tbl = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        dut_chain = '1;
        base = setup_total;
        run_load(99, 99);
        check("zero_setup_cnt", setup_total - base, TOTAL);
        check("zero_chain",     dut_chain, 44'h0);
        check("zero_model",     m_chain,   44'h0);
        tick();

        // Reset in the middle of shifting drops outputs immediately.
        start = 1'b1;
        tick();
        start    = 1'b0;
        in_data  = 8'hC3;
        in_valid = 1'b1;
        wait_ready("rst_ready_timeout");
        tick();
        in_valid = 1'b0;
        tick();
        check("pre_rst_setup", setup, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_setup",    setup,     1'b0);
        check("mid_rst_param",    param_out, 1'b0);
        check("mid_rst_busy",     busy,      1'b0);
        check("mid_rst_in_ready", in_ready,  1'b0);
        check("mid_rst_done",     done,      1'b0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_done", done, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
